id_ex_stage: RTL and testbench

//  ID/EX pipeline stage directly downstream of the register file. Captures register operands,

---
 rtl/id_ex_stage_pkg.sv | 18 +
 rtl/id_ex_stage_hazard.sv | 20 ++
 rtl/id_ex_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: control-bundle bit map and register specifier constants.
package id_ex_stage_pkg;

    localparam int CTRL_W_DEF    = 8;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 5;
    localparam int CTRL_ALUOP_LO = 6;
    localparam int CTRL_ALUOP_HI = 7;

    localparam int               REG_W    = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detection: a load sitting in EX whose destination is read by the ID instruction.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             ex_valid_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    output logic             stall_o
);

    // rt is compared for every instruction, even ones that do not read it; a rare extra bubble is harmless.
    always_comb begin
        stall_o = id_valid_i && ex_valid_i && ex_memread_i && (ex_rt_i != REG_ZERO)
                  && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID bypass, load-use bubble insertion, flush and a
// saturating stall-cycle counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_read_data1,
    input  logic [DATA_W-1:0] id_read_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_writereg,
    input  logic [DATA_W-1:0] wb_writedata,
    output logic              stall,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    logic              ex_valid_q,    ex_valid_d;
    logic [REG_W-1:0]  ex_rs_q,       ex_rs_d;
    logic [REG_W-1:0]  ex_rt_q,       ex_rt_d;
    logic [REG_W-1:0]  ex_rd_q,       ex_rd_d;
    logic [DATA_W-1:0] ex_a_q,        ex_a_d;
    logic [DATA_W-1:0] ex_b_q,        ex_b_d;
    logic [DATA_W-1:0] ex_imm_q,      ex_imm_d;
    logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    // $0 reads zero; otherwise a same-cycle WB write wins over the (not yet written) regfile value.
    function automatic logic [DATA_W-1:0] bypass(
        input logic [REG_W-1:0]  src,
        input logic [DATA_W-1:0] rf_data,
        input logic              wr_en,
        input logic [REG_W-1:0]  wr_reg,
        input logic [DATA_W-1:0] wr_data
    );
        if (src == REG_ZERO)
            return '0;
        if (wr_en && (wr_reg == src))
            return wr_data;
        return rf_data;
    endfunction

    hazard_detect u_hazard (
        .id_valid_i   (id_valid),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .ex_valid_i   (ex_valid_q),
        .ex_memread_i (ex_ctrl_q[CTRL_MEMREAD]),
        .ex_rt_i      (ex_rt_q),
        .stall_o      (stall)
    );

    always_comb begin
        // NOTE: every next-state signal defaults to its held value first, so no path infers a latch.
        ex_valid_d    = ex_valid_q;
        ex_rs_d       = ex_rs_q;
        ex_rt_d       = ex_rt_q;
        ex_rd_d       = ex_rd_q;
        ex_a_d        = ex_a_q;
        ex_b_d        = ex_b_q;
        ex_imm_d      = ex_imm_q;
        ex_ctrl_d     = ex_ctrl_q;
        stall_count_d = stall_count_q;

        // Flush and stall produce the same bubble; datapath fields are simply held.
        if (flush || stall) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else begin
            ex_valid_d = id_valid;
            ex_ctrl_d  = id_valid ? id_ctrl : '0;
            ex_rs_d    = id_rs;
            ex_rt_d    = id_rt;
            ex_rd_d    = id_rd;
            ex_a_d     = bypass(id_rs, id_read_data1, wb_regwrite, wb_writereg, wb_writedata);
            ex_b_d     = bypass(id_rt, id_read_data2, wb_regwrite, wb_writereg, wb_writedata);
            ex_imm_d   = id_imm;
        end

        if (stall && !flush && (stall_count_q != '1))
            stall_count_d = stall_count_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all of them sample the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_rd_q       <= '0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_imm_q      <= '0;
            ex_ctrl_q     <= '0;
            stall_count_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
            ex_rd_q       <= ex_rd_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_imm_q      <= ex_imm_d;
            ex_ctrl_q     <= ex_ctrl_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_rs       = ex_rs_q;
    assign ex_rt       = ex_rt_q;
    assign ex_rd       = ex_rd_q;
    assign ex_a        = ex_a_q;
    assign ex_b        = ex_b_q;
    assign ex_imm      = ex_imm_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural model of the stage.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int DW = 32;
    localparam int CW = CTRL_W_DEF;

    localparam logic [CW-1:0] C_ALU = CW'(1 << CTRL_REGWRITE) | CW'(1 << CTRL_REGDST) | CW'(1 << CTRL_ALUOP_HI);
    localparam logic [CW-1:0] C_LW  = CW'(1 << CTRL_REGWRITE) | CW'(1 << CTRL_MEMREAD)
                                    | CW'(1 << CTRL_MEMTOREG) | CW'(1 << CTRL_ALUSRC);
    localparam logic [CW-1:0] C_SW  = CW'(1 << CTRL_MEMWRITE) | CW'(1 << CTRL_ALUSRC) | CW'(1 << CTRL_ALUOP_LO);

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          id_valid;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic [DW-1:0] id_read_data1, id_read_data2, id_imm;
    logic [CW-1:0] id_ctrl;
    logic          wb_regwrite;
    logic [4:0]    wb_writereg;
    logic [DW-1:0] wb_writedata;

    logic          stall, ex_valid;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_a, ex_b, ex_imm;
    logic [CW-1:0] ex_ctrl;
    logic [15:0]   stall_count;

    logic          s_stall, s_ex_valid;
    logic [4:0]    s_ex_rs, s_ex_rt, s_ex_rd;
    logic [DW-1:0] s_ex_a, s_ex_b, s_ex_imm;
    logic [CW-1:0] s_ex_ctrl;
    logic [3:0]    s_stall_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
        .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .stall_count(stall_count)
    );

    id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
        .stall(s_stall), .ex_valid(s_ex_valid), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd),
        .ex_a(s_ex_a), .ex_b(s_ex_b), .ex_imm(s_ex_imm), .ex_ctrl(s_ex_ctrl), .stall_count(s_stall_count)
    );

    // Behavioural model: what EX must hold, and how many stall cycles have been counted.
    typedef struct {
        logic          valid;
        logic [4:0]    rs, rt, rd;
        logic [DW-1:0] a, b, imm;
        logic [CW-1:0] ctrl;
    } ex_t;

    ex_t         m;
    int unsigned m_cnt16;
    int unsigned m_cnt4;

    function automatic bit model_stall();
        return id_valid && m.valid && m.ctrl[CTRL_MEMREAD] && (m.rt != 5'd0)
               && ((m.rt == id_rs) || (m.rt == id_rt));
    endfunction

    function automatic logic [DW-1:0] operand(input logic [4:0] r, input logic [DW-1:0] rf);
        if (r == 5'd0) return '0;
        if (wb_regwrite && (wb_writereg == r)) return wb_writedata;
        return rf;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m       <= '{valid: 1'b0, rs: '0, rt: '0, rd: '0, a: '0, b: '0, imm: '0, ctrl: '0};
            m_cnt16 <= 0;
            m_cnt4  <= 0;
        end else begin
            if (model_stall() && !flush) begin
                if (m_cnt16 < 65535) m_cnt16 <= m_cnt16 + 1;
                if (m_cnt4 < 15)     m_cnt4  <= m_cnt4 + 1;
            end
            if (flush || model_stall()) begin
                m.valid <= 1'b0;
                m.ctrl  <= '0;
            end else begin
                m <= '{valid: id_valid, rs: id_rs, rt: id_rt, rd: id_rd,
                       a: operand(id_rs, id_read_data1), b: operand(id_rt, id_read_data2),
                       imm: id_imm, ctrl: (id_valid ? id_ctrl : '0)};
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall",         64'(stall),         64'(model_stall()));
            check("ex_valid",      64'(ex_valid),      64'(m.valid));
            check("ex_ctrl",       64'(ex_ctrl),       64'(m.ctrl));
            check("ex_rs",         64'(ex_rs),         64'(m.rs));
            check("ex_rt",         64'(ex_rt),         64'(m.rt));
            check("ex_rd",         64'(ex_rd),         64'(m.rd));
            check("ex_a",          64'(ex_a),          64'(m.a));
            check("ex_b",          64'(ex_b),          64'(m.b));
            check("ex_imm",        64'(ex_imm),        64'(m.imm));
            check("stall_count",   64'(stall_count),   64'(m_cnt16));
            check("s_stall",       64'(s_stall),       64'(model_stall()));
            check("s_ex_a",        64'(s_ex_a),        64'(m.a));
            check("s_stall_count", 64'(s_stall_count), 64'(m_cnt4));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_read_data1 = 0; id_read_data2 = 0; id_imm = 0; id_ctrl = 0;
        wb_regwrite = 0; wb_writereg = 0; wb_writedata = 0;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [CW-1:0] ctrl);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = 5'd9; id_ctrl = ctrl;
        id_read_data1 = 32'h1000 + 32'(rs); id_read_data2 = 32'h2000 + 32'(rt); id_imm = 32'h4;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        step();

        // Pass-through with sign-extended immediate.
        issue(5'd3, 5'd4, C_ALU);
        id_read_data1 = 32'h11; id_read_data2 = 32'h22; id_imm = 32'hFFFF_FFF0;
        step();
        check("pass ex_a",     64'(ex_a),     64'h11);
        check("pass ex_b",     64'(ex_b),     64'h22);
        check("pass ex_imm",   64'(ex_imm),   64'hFFFF_FFF0);
        check("pass ex_valid", 64'(ex_valid), 64'd1);

        // Load-use on rt=5: one stall cycle, one bubble, then the consumer proceeds.
        issue(5'd1, 5'd5, C_LW);
        step();
        issue(5'd5, 5'd6, C_ALU);
        #1 check("lu stall", 64'(stall), 64'd1);
        step();
        check("lu bubble valid", 64'(ex_valid),    64'd0);
        check("lu bubble ctrl",  64'(ex_ctrl),     64'd0);
        check("lu stall drops",  64'(stall),       64'd0);
        check("lu stall_count",  64'(stall_count), 64'd1);
        step();
        check("lu consumer valid", 64'(ex_valid), 64'd1);
        check("lu consumer rs",    64'(ex_rs),    64'd5);

        // Load targeting $0 never stalls.
        issue(5'd1, 5'd0, C_LW);
        step();
        issue(5'd0, 5'd0, C_ALU);
        #1 check("lu r0 no stall", 64'(stall), 64'd0);
        step();
        check("lu r0 count", 64'(stall_count), 64'd1);

        // WB->ID bypass, and $0 ignores a WB write to $0.
        issue(5'd7, 5'd2, C_SW);
        id_read_data1 = 32'h0;
        wb_regwrite = 1; wb_writereg = 5'd7; wb_writedata = 32'hDEAD_BEEF;
        step();
        check("bypass ex_a", 64'(ex_a), 64'hDEAD_BEEF);
        issue(5'd0, 5'd2, C_ALU);
        id_read_data1 = 32'h55;
        wb_writereg = 5'd0;
        step();
        check("bypass r0 ex_a", 64'(ex_a), 64'h0);
        wb_regwrite = 0;

        // Flush coinciding with a stall, then flush alone.
        issue(5'd1, 5'd5, C_LW);
        step();
        issue(5'd5, 5'd6, C_ALU);
        flush = 1;
        #1 check("fs stall", 64'(stall), 64'd1);
        step();
        flush = 0;
        check("fs bubble valid", 64'(ex_valid),    64'd0);
        check("fs bubble ctrl",  64'(ex_ctrl),     64'd0);
        check("fs count held",   64'(stall_count), 64'd1);
        step();
        issue(5'd2, 5'd3, C_ALU);
        flush = 1;
        step();
        flush = 0;
        check("flush valid", 64'(ex_valid), 64'd0);
        check("flush ctrl",  64'(ex_ctrl),  64'd0);

        // Asynchronous reset mid-cycle with a load sitting in EX.
        issue(5'd1, 5'd5, C_LW);
        step();
        issue(5'd5, 5'd6, C_ALU);
        #2 reset = 1;
        #1;
        check("rst stall",       64'(stall),       64'd0);
        check("rst ex_valid",    64'(ex_valid),    64'd0);
        check("rst ex_ctrl",     64'(ex_ctrl),     64'd0);
        check("rst ex_a",        64'(ex_a),        64'd0);
        check("rst ex_rt",       64'(ex_rt),       64'd0);
        check("rst stall_count", 64'(stall_count), 64'd0);
        step();
        reset = 0;
        idle_inputs();
        step();

        // Twenty load-use stalls saturate the 4-bit counter at 15.
        for (int i = 0; i < 20; i++) begin
            issue(5'd1, 5'd5, C_LW);
            step();
            issue(5'd5, 5'd6, C_ALU);
            step();
        end
        idle_inputs();
        step();
        check("sat count4",  64'(s_stall_count), 64'd15);
        check("sat count16", 64'(stall_count),   64'd20);

        // Randomized traffic with small register ranges so hazards and bypasses are frequent.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            id_valid      = ($urandom_range(0, 9) < 8);
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            id_rd         = 5'($urandom_range(0, 31));
            id_read_data1 = $urandom;
            id_read_data2 = $urandom;
            id_imm        = $urandom;
            id_ctrl       = CW'($urandom);
            if ($urandom_range(0, 1) == 1) id_ctrl[CTRL_MEMREAD] = 1'b1;
            flush         = ($urandom_range(0, 9) == 0);
            wb_regwrite   = ($urandom_range(0, 1) == 1);
            wb_writereg   = 5'($urandom_range(0, 7));
            wb_writedata  = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1;
                #2 reset = 0;
            end
        end

        idle_inputs();
        step();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
